// File: rtl/alu_bist_sequencer.sv
// Built-in self-test sequencer for a 32-bit ALU: drives LFSR operand pairs through
// all ten opcodes and folds every result into a MISR signature checked against GOLDEN_SIG.
module alu_bist_sequencer #(
    parameter int unsigned NUM_VECTORS = 64,
    parameter logic [31:0] SEED_A      = 32'h0000_0001,
    parameter logic [31:0] SEED_B      = 32'hDEAD_BEEF,
    parameter logic [31:0] GOLDEN_SIG  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [31:0] alu_data_1,
    output logic [31:0] alu_data_2,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_result,
    output logic [31:0] signature
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0]  OP_ADD    = 4'b0001;
    localparam logic [3:0]  OP_NOP    = 4'b1111;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
    localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;
    localparam logic [15:0] LAST_VEC  = 16'(NUM_VECTORS - 1);
    // An all-zero LFSR would lock up, so a zero seed is replaced with 1.
    localparam logic [31:0] SEED_A_EFF = (SEED_A == 32'h0) ? 32'h1 : SEED_A;
    localparam logic [31:0] SEED_B_EFF = (SEED_B == 32'h0) ? 32'h1 : SEED_B;

    state_t      state_q;
    logic [15:0] vecCnt_q;
    logic [3:0]  opIdx_q;
    logic [31:0] sig_q;
    logic [31:0] aluA_q;
    logic [31:0] aluB_q;
    logic [3:0]  aluOp_q;
    logic        busy_q;
    logic        done_q;
    logic        pass_q;

    logic [31:0] sig_d;
    logic [31:0] lfsrA_d;
    logic [31:0] lfsrB_d;

    function automatic logic [3:0] opcodeFor(input logic [3:0] idx);
        case (idx)
            4'd0:    return 4'b0001;
            4'd1:    return 4'b0010;
            4'd2:    return 4'b0100;
            4'd3:    return 4'b0101;
            4'd4:    return 4'b0110;
            4'd5:    return 4'b1000;
            4'd6:    return 4'b1001;
            4'd7:    return 4'b1010;
            4'd8:    return 4'b1100;
            4'd9:    return 4'b1101;
            default: return OP_NOP;
        endcase
    endfunction

    // The operand outputs double as the LFSR state while running.
    always_comb begin
        sig_d   = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? MISR_POLY : 32'h0) ^ alu_result;
        lfsrA_d = {1'b0, aluA_q[31:1]} ^ (aluA_q[0] ? LFSR_TAPS : 32'h0);
        lfsrB_d = {1'b0, aluB_q[31:1]} ^ (aluB_q[0] ? LFSR_TAPS : 32'h0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            vecCnt_q <= 16'h0;
            opIdx_q  <= 4'h0;
            sig_q    <= 32'h0;
            aluA_q   <= 32'h0;
            aluB_q   <= 32'h0;
            aluOp_q  <= OP_NOP;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q  <= RUN;
                        vecCnt_q <= 16'h0;
                        opIdx_q  <= 4'h0;
                        sig_q    <= 32'h0;
                        aluA_q   <= SEED_A_EFF;
                        aluB_q   <= SEED_B_EFF;
                        aluOp_q  <= OP_ADD;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                        pass_q   <= 1'b0;
                    end
                end
                RUN: begin
                    // Each edge in RUN captures the result of the triple presented last cycle.
                    sig_q <= sig_d;
                    if (opIdx_q == 4'd9) begin
                        opIdx_q <= 4'h0;
                        if (vecCnt_q == LAST_VEC) begin
                            state_q  <= DONE;
                            vecCnt_q <= 16'h0;
                            aluA_q   <= 32'h0;
                            aluB_q   <= 32'h0;
                            aluOp_q  <= OP_NOP;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            pass_q   <= (sig_d == GOLDEN_SIG);
                        end else begin
                            vecCnt_q <= vecCnt_q + 16'd1;
                            aluA_q   <= lfsrA_d;
                            aluB_q   <= lfsrB_d;
                            aluOp_q  <= OP_ADD;
                        end
                    end else begin
                        opIdx_q <= opIdx_q + 4'd1;
                        aluOp_q <= opcodeFor(opIdx_q + 4'd1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign alu_data_1 = aluA_q;
    assign alu_data_2 = aluB_q;
    assign alu_op     = aluOp_q;
    assign signature  = sig_q;

endmodule

// File: tb/tb_alu_bist_sequencer.sv
// Self-checking bench for alu_bist_sequencer: four parameterisations driven by a
// behavioural ALU, checked against a vector-level signature model.
module tb_alu_bist_sequencer;

    localparam logic [3:0] OP_NOP = 4'b1111;

    function automatic logic [3:0] opcodeOf(input int i);
        case (i)
            0:       return 4'b0001;
            1:       return 4'b0010;
            2:       return 4'b0100;
            3:       return 4'b0101;
            4:       return 4'b0110;
            5:       return 4'b1000;
            6:       return 4'b1001;
            7:       return 4'b1010;
            8:       return 4'b1100;
            9:       return 4'b1101;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] aluModel(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'b0001: return a + b;
            4'b0010: return a - b;
            4'b0100: return a & b;
            4'b0101: return a | b;
            4'b0110: return a ^ b;
            4'b1000: return a << b[4:0];
            4'b1001: return a >> b[4:0];
            4'b1010: return 32'($signed(a) >>> b[4:0]);
            4'b1100: return {31'h0, $signed(a) < $signed(b)};
            4'b1101: return {31'h0, a < b};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] lfsrStep(input logic [31:0] x);
        return {1'b0, x[31:1]} ^ (x[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    function automatic logic [31:0] misrStep(input logic [31:0] s, input logic [31:0] r);
        return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C1_1DB7 : 32'h0) ^ r;
    endfunction

    function automatic logic [31:0] effSeed(input logic [31:0] s);
        return (s == 32'h0) ? 32'h1 : s;
    endfunction

    // Whole-run signature: every vector runs all ten ops, then both operands step once.
    function automatic logic [31:0] modelSignature(input int nVec, input logic [31:0] seedA, input logic [31:0] seedB);
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] s;
        a = effSeed(seedA);
        b = effSeed(seedB);
        s = 32'h0;
        for (int v = 0; v < nVec; v++) begin
            for (int i = 0; i < 10; i++) begin
                s = misrStep(s, aluModel(opcodeOf(i), a, b));
            end
            a = lfsrStep(a);
            b = lfsrStep(b);
        end
        return s;
    endfunction

    localparam logic [31:0] MODEL_SIG  = modelSignature(64, 32'h0000_0001, 32'hDEAD_BEEF);
    localparam logic [31:0] MODEL_ZERO = modelSignature(5, 32'h0, 32'h1234_5678);
    localparam logic [31:0] SEED_A_OF [4] = '{32'd25, 32'h1, 32'h1, 32'h0};
    localparam logic [31:0] SEED_B_OF [4] = '{32'd7, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h1234_5678};

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  startV;
    logic [3:0]  busyV;
    logic [3:0]  doneV;
    logic [3:0]  passV;
    logic [31:0] dataA [4];
    logic [31:0] dataB [4];
    logic [31:0] resV [4];
    logic [31:0] sigV [4];
    logic [3:0]  opV [4];

    int checkCount = 0;
    int errorCount = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : gAlu
        assign resV[g] = aluModel(opV[g], dataA[g], dataB[g]);
    end

    alu_bist_sequencer #(.NUM_VECTORS(1), .SEED_A(32'd25), .SEED_B(32'd7)) dutSmall (
        .clk(clk), .rst(rst), .start(startV[0]), .busy(busyV[0]), .done(doneV[0]), .pass(passV[0]),
        .alu_data_1(dataA[0]), .alu_data_2(dataB[0]), .alu_op(opV[0]), .alu_result(resV[0]),
        .signature(sigV[0]));

    alu_bist_sequencer #(.GOLDEN_SIG(MODEL_SIG)) dutGold (
        .clk(clk), .rst(rst), .start(startV[1]), .busy(busyV[1]), .done(doneV[1]), .pass(passV[1]),
        .alu_data_1(dataA[1]), .alu_data_2(dataB[1]), .alu_op(opV[1]), .alu_result(resV[1]),
        .signature(sigV[1]));

    alu_bist_sequencer #(.GOLDEN_SIG(MODEL_SIG ^ 32'h1)) dutBad (
        .clk(clk), .rst(rst), .start(startV[2]), .busy(busyV[2]), .done(doneV[2]), .pass(passV[2]),
        .alu_data_1(dataA[2]), .alu_data_2(dataB[2]), .alu_op(opV[2]), .alu_result(resV[2]),
        .signature(sigV[2]));

    alu_bist_sequencer #(.NUM_VECTORS(5), .SEED_A(32'h0), .SEED_B(32'h1234_5678), .GOLDEN_SIG(MODEL_ZERO)) dutZero (
        .clk(clk), .rst(rst), .start(startV[3]), .busy(busyV[3]), .done(doneV[3]), .pass(passV[3]),
        .alu_data_1(dataA[3]), .alu_data_2(dataB[3]), .alu_op(opV[3]), .alu_result(resV[3]),
        .signature(sigV[3]));

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Pulses start for one edge; returns at the negedge after that edge.
    task automatic applyStimulus(input int idx);
        startV[idx] = 1'b1;
        @(negedge clk);
        startV[idx] = 1'b0;
    endtask

    // Follows a run to DONE, comparing each presented triple with the vector model.
    task automatic runToDone(input int idx, input int pokeAt, output int busyCnt);
        logic [31:0] mA;
        logic [31:0] mB;
        int t;
        int seqErr;
        int bothErr;
        mA = effSeed(SEED_A_OF[idx]);
        mB = effSeed(SEED_B_OF[idx]);
        t = 0;
        busyCnt = 0;
        seqErr = 0;
        bothErr = 0;
        while (doneV[idx] !== 1'b1 && t < 20000) begin
            if (busyV[idx] === 1'b1 && doneV[idx] === 1'b1) bothErr++;
            if (busyV[idx] === 1'b1) begin
                if (busyCnt > 0 && busyCnt % 10 == 0) begin
                    mA = lfsrStep(mA);
                    mB = lfsrStep(mB);
                end
                if (dataA[idx] !== mA || dataB[idx] !== mB || opV[idx] !== opcodeOf(busyCnt % 10)) seqErr++;
                busyCnt++;
            end
            startV[idx] = (t == pokeAt);
            t++;
            @(negedge clk);
        end
        startV[idx] = 1'b0;
        checkOutput("done_reached", 32'(doneV[idx]), 32'h1);
        checkOutput("busy_at_done", 32'(busyV[idx]), 32'h0);
        checkOutput("operand_sequence_errors", seqErr, 0);
        checkOutput("busy_done_overlap", bothErr, 0);
    endtask

    initial begin
        logic [31:0] expRes [10];
        logic [31:0] sigM;
        int bc;
        int poke;
        expRes = '{32'd32, 32'd18, 32'd1, 32'd31, 32'd30, 32'd3200, 32'd0, 32'd0, 32'd0, 32'd0};

        rst = 1'b1;
        startV = 4'h0;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", 32'(busyV[0]), 32'h0);
        checkOutput("reset_done", 32'(doneV[1]), 32'h0);
        checkOutput("reset_op", 32'(opV[0]), 32'(OP_NOP));
        checkOutput("reset_sig", sigV[1], 32'h0);
        checkOutput("reset_data1", dataA[0], 32'h0);
        rst = 1'b0;

        // Single vector with known operands: hand-computed ALU results.
        repeat ($urandom_range(1, 4)) @(negedge clk);
        applyStimulus(0);
        sigM = 32'h0;
        for (int j = 0; j < 10; j++) begin
            checkOutput("small_data1", dataA[0], 32'd25);
            checkOutput("small_data2", dataB[0], 32'd7);
            checkOutput("small_op", 32'(opV[0]), 32'(opcodeOf(j)));
            checkOutput("small_result", resV[0], expRes[j]);
            checkOutput("small_sig", sigV[0], sigM);
            checkOutput("small_busy", 32'(busyV[0]), 32'h1);
            checkOutput("small_done_early", 32'(doneV[0]), 32'h0);
            sigM = misrStep(sigM, expRes[j]);
            @(negedge clk);
        end
        checkOutput("small_done", 32'(doneV[0]), 32'h1);
        checkOutput("small_busy_end", 32'(busyV[0]), 32'h0);
        checkOutput("small_sig_final", sigV[0], sigM);
        checkOutput("small_pass", 32'(passV[0]), 32'(sigM == 32'h0));
        checkOutput("small_op_idle", 32'(opV[0]), 32'(OP_NOP));
        checkOutput("small_data1_idle", dataA[0], 32'h0);

        repeat ($urandom_range(1, 6)) @(negedge clk);
        applyStimulus(1);
        runToDone(1, -1, bc);
        checkOutput("gold_busy_cycles", bc, 640);
        checkOutput("gold_pass", 32'(passV[1]), 32'h1);
        checkOutput("gold_sig", sigV[1], MODEL_SIG);

        repeat ($urandom_range(1, 6)) @(negedge clk);
        applyStimulus(2);
        runToDone(2, -1, bc);
        checkOutput("bad_busy_cycles", bc, 640);
        checkOutput("bad_pass", 32'(passV[2]), 32'h0);
        checkOutput("bad_sig", sigV[2], MODEL_SIG);

        // Reset in the middle of a run, then a fresh run.
        applyStimulus(1);
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_busy", 32'(busyV[1]), 32'h0);
        checkOutput("midrst_done", 32'(doneV[1]), 32'h0);
        checkOutput("midrst_pass", 32'(passV[1]), 32'h0);
        checkOutput("midrst_sig", sigV[1], 32'h0);
        checkOutput("midrst_op", 32'(opV[1]), 32'(OP_NOP));
        checkOutput("midrst_data1", dataA[1], 32'h0);
        checkOutput("midrst_data2", dataB[1], 32'h0);
        rst = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        checkOutput("midrst_idle_busy", 32'(busyV[1]), 32'h0);
        applyStimulus(1);
        runToDone(1, -1, bc);
        checkOutput("rerun_busy_cycles", bc, 640);
        checkOutput("rerun_sig", sigV[1], MODEL_SIG);
        checkOutput("rerun_pass", 32'(passV[1]), 32'h1);

        // Start pulse during RUN must be ignored; start in DONE restarts.
        poke = $urandom_range(20, 600);
        applyStimulus(1);
        runToDone(1, poke, bc);
        checkOutput("poke_busy_cycles", bc, 640);
        checkOutput("poke_sig", sigV[1], MODEL_SIG);
        repeat ($urandom_range(1, 4)) @(negedge clk);
        applyStimulus(1);
        checkOutput("restart_done", 32'(doneV[1]), 32'h0);
        checkOutput("restart_busy", 32'(busyV[1]), 32'h1);
        checkOutput("restart_sig", sigV[1], 32'h0);
        checkOutput("restart_data1", dataA[1], 32'h1);
        checkOutput("restart_data2", dataB[1], 32'hDEAD_BEEF);
        checkOutput("restart_op", 32'(opV[1]), 32'h1);
        runToDone(1, -1, bc);
        checkOutput("restart_busy_cycles", bc, 640);
        checkOutput("restart_sig_final", sigV[1], MODEL_SIG);

        // Reset and start asserted together from IDLE.
        rst = 1'b1;
        @(negedge clk);
        startV[0] = 1'b1;
        @(negedge clk);
        checkOutput("rststart_busy", 32'(busyV[0]), 32'h0);
        checkOutput("rststart_done", 32'(doneV[0]), 32'h0);
        checkOutput("rststart_op", 32'(opV[0]), 32'(OP_NOP));
        rst = 1'b0;
        startV[0] = 1'b0;
        @(negedge clk);
        checkOutput("rststart_idle_busy", 32'(busyV[0]), 32'h0);

        // Zero seed is replaced by 1.
        applyStimulus(3);
        checkOutput("zero_seed_data1", dataA[3], 32'h1);
        runToDone(3, -1, bc);
        checkOutput("zero_busy_cycles", bc, 50);
        checkOutput("zero_sig", sigV[3], MODEL_ZERO);
        checkOutput("zero_pass", 32'(passV[3]), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/alu_bist_sequencer.md
ALU_BIST_SEQUENCER -- requirements
Module: alu_bist_sequencer

Interface
REQ-001 SHALL have parameter NUM_VECTORS, default 64, operand pairs per run (legal range 1..65535).
REQ-002 SHALL have parameter SEED_A, default 32'h0000_0001, initial operand-A LFSR value.
REQ-003 SHALL have parameter SEED_B, default 32'hDEAD_BEEF, initial operand-B LFSR value.
REQ-004 SHALL have parameter GOLDEN_SIG, default 32'h0000_0000, expected final signature.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port start  input  1  begin a self-test run.
REQ-008 SHALL have port busy  output  1  run in progress.
REQ-009 SHALL have port done  output  1  run complete; held until next accepted start.
REQ-010 SHALL have port pass  output  1  final signature equals GOLDEN_SIG; valid only while done=1.
REQ-011 SHALL have port alu_data_1  output  32  operand A to the ALU.
REQ-012 SHALL have port alu_data_2  output  32  operand B to the ALU.
REQ-013 SHALL have port alu_op  output  4  ALU opcode (ADD 0001, SUB 0010, AND 0100, OR 0101, XOR 0110, SLL 1000, SRL 1001, SRA 1010, SLT 1100, SLTU 1101, NOP 1111).
REQ-014 SHALL have port alu_result  input  32  combinational ALU result for the presented operands and opcode.
REQ-015 SHALL have port signature  output  32  current MISR value.

Function
REQ-016 SHALL implement states IDLE, RUN, DONE; all outputs registered.
REQ-017 SHALL, in IDLE and DONE, drive alu_op=NOP, alu_data_1=0, alu_data_2=0.
REQ-018 SHALL accept start only in IDLE or DONE; start in RUN ignored.
REQ-019 On accepted start at edge k: SHALL enter RUN, clear signature to 0, clear done and pass, load LFSR_A=SEED_A and LFSR_B=SEED_B, present vector 0 / op index 0 on the ALU outputs.
REQ-020 SHALL present one (A,B,op) triple per cycle in RUN, with op index 0..9 mapping to ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU in that order.
REQ-021 SHALL hold A and B for all 10 ops of a vector, then advance both LFSRs once before the next vector's op 0.
REQ-022 SHALL advance each LFSR as next = {1'b0, x[31:1]} ^ (x[0] ? 32'h8020_0003 : 32'h0).
REQ-023 SHALL substitute 32'h0000_0001 for any seed parameter equal to zero.
REQ-024 SHALL sample alu_result at every edge following a RUN presentation cycle (1-cycle capture latency).
REQ-025 SHALL update the MISR per capture as sig_next = ({sig[30:0],1'b0} ^ (sig[31] ? 32'h04C1_1DB7 : 32'h0)) ^ alu_result.
REQ-026 SHALL present exactly 10*NUM_VECTORS triples; at edge k+10*NUM_VECTORS, it SHALL capture the last result, enter DONE, set done=1, and set pass=(sig_next==GOLDEN_SIG).
REQ-027 SHALL assert busy exactly while in RUN; busy and done never both 1.
REQ-028 SHALL keep the 16-bit vector counter and 4-bit op counter free of wrap-around before the terminal count.
REQ-029 SHALL accept start in DONE as a full restart per REQ-019 (done drops at that edge).

Reset
REQ-030 On rst=1 at any edge, including mid-RUN, SHALL enter IDLE with busy=0, done=0, pass=0, signature=0, alu_op=NOP, alu_data_1=0, alu_data_2=0, and counters 0.
REQ-031 rst SHALL take priority over a simultaneous start.

Verification
REQ-032 With NUM_VECTORS=1, SEED_A=25, SEED_B=7, pulse start: the bench SHALL check alu_data_1=25 and alu_data_2=7 for 10 cycles, the op order per REQ-020, and captured results 32, 18, 1, 31, 30, 3200, 0, 0, 0, 0; done rises 10 cycles after the start edge.
REQ-033 Default parameters, GOLDEN_SIG set to the bench model's signature: the bench SHALL check done=1, pass=1, signature=model, and busy high for exactly 640 cycles.
REQ-034 Same run with GOLDEN_SIG = model^32'h1: the bench SHALL check done=1 and pass=0.
REQ-035 Assert rst at cycle 100 of a run: the bench SHALL check that all outputs reach reset values next cycle; a fresh start then reproduces the REQ-033 signature.
REQ-036 Pulse start during RUN and again in DONE: the bench SHALL check the RUN pulse has no effect and the DONE pulse restarts the run (done=0, signature=0, vector 0 re-presented).
REQ-037 Assert rst and start together in IDLE: the bench SHALL check the block stays in IDLE with busy=0.
